// File: rtl/reset_pkg.sv
// Shared types and defaults for the reset sequencer and its input debouncers.
package reset_pkg;

  // Sequencer states, ordered as they are visited on a clean power-up.
  typedef enum logic [2:0] {
    ST_ASSERT,
    ST_WAIT_RELEASE,
    ST_HOLD,
    ST_RELEASE,
    ST_RUNNING
  } state_e;

  localparam int DEFAULT_DEBOUNCE_CLKS = 16;
  localparam int DEFAULT_HOLD_CLKS     = 7;
  localparam int DEFAULT_STAGGER_CLKS  = 4;

  // Width of a down-counter that must hold values up to n.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Request inputs and domain reset outputs of the reset sequencer.
interface reset_sequencer_if #(
  parameter int NUM_SOURCES = 2,
  parameter int NUM_DOMAINS = 3
);
  logic [NUM_SOURCES-1:0] src_i;
  logic [NUM_DOMAINS-1:0] rst_o;
  logic                   done_o;
  logic                   led_reset_o;
  logic [NUM_SOURCES-1:0] cause_o;

  // Sequencer side.
  modport master (
    input  src_i,
    output rst_o, done_o, led_reset_o, cause_o
  );

  // Request sources and reset consumers.
  modport slave (
    output src_i,
    input  rst_o, done_o, led_reset_o, cause_o
  );
endinterface

// File: rtl/reset_debounce.sv
// One reset request input: 2-FF synchroniser, polarity fix-up, debounce.
// The debounced level changes 2 + DEBOUNCE_CLKS edges after a raw edge.
module reset_debounce
  import reset_pkg::*;
#(
  parameter bit ACTIVE_LOW    = 1'b0,
  parameter int DEBOUNCE_CLKS = DEFAULT_DEBOUNCE_CLKS
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic src_i,
  output logic req_o
);

  localparam int CW = cnt_width(DEBOUNCE_CLKS);

  logic [1:0]    sync;
  logic          req_sync;
  logic [CW-1:0] cnt;

  assign req_sync = sync[1] ^ ACTIVE_LOW;

  // Two-stage synchroniser for the asynchronous raw input.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      // NOTE: reset to the raw inactive level so no request appears after reset.
      sync <= {2{ACTIVE_LOW}};
    end else begin
      // NOTE: non-blocking so sync[1] takes the old sync[0], forming two stages.
      sync <= {sync[0], src_i};
    end
  end

  // Count consecutive disagreeing cycles down; flip the level when exhausted.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt   <= '0;
      req_o <= 1'b0;
    end else if (req_sync == req_o) begin
      cnt <= CW'(DEBOUNCE_CLKS - 1);
    end else if (cnt == '0) begin
      req_o <= req_sync;
      cnt   <= CW'(DEBOUNCE_CLKS - 1);
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Multi-source reset sequencer: asserts all domain resets together and
// releases them one at a time, lowest index first.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int                     NUM_SOURCES    = 2,
  parameter int                     NUM_DOMAINS    = 3,
  parameter logic [NUM_SOURCES-1:0] SRC_ACTIVE_LOW = NUM_SOURCES'(2'b10),
  parameter int                     DEBOUNCE_CLKS  = DEFAULT_DEBOUNCE_CLKS,
  parameter int                     HOLD_CLKS      = DEFAULT_HOLD_CLKS,
  parameter int                     STAGGER_CLKS   = DEFAULT_STAGGER_CLKS
) (
  input logic               clk_i,
  input logic               reset_i,
  reset_sequencer_if.master bus
);

  localparam int HW = cnt_width(HOLD_CLKS);
  localparam int SW = cnt_width(STAGGER_CLKS);
  localparam int IW = cnt_width(NUM_DOMAINS);

  logic [NUM_SOURCES-1:0] req;
  logic                   req_any;
  state_e                 state;
  logic [HW-1:0]          hold_cnt;
  logic [SW-1:0]          stag_cnt;
  logic [IW-1:0]          dom_idx;

  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_src
    reset_debounce #(
      .ACTIVE_LOW   (SRC_ACTIVE_LOW[i]),
      .DEBOUNCE_CLKS(DEBOUNCE_CLKS)
    ) u_debounce (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .src_i  (bus.src_i[i]),
      .req_o  (req[i])
    );
  end

  assign req_any = |req;

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state           <= ST_ASSERT;
      hold_cnt        <= '0;
      stag_cnt        <= '0;
      dom_idx         <= '0;
      bus.rst_o       <= '1;
      bus.done_o      <= 1'b0;
      bus.led_reset_o <= 1'b1;
      bus.cause_o     <= '0;
    end else if (req_any && (state == ST_HOLD || state == ST_RELEASE ||
                             state == ST_RUNNING)) begin
      // A new request always wins: re-assert everything, no partial release.
      state           <= ST_WAIT_RELEASE;
      bus.rst_o       <= '1;
      bus.done_o      <= 1'b0;
      bus.led_reset_o <= 1'b1;
      bus.cause_o     <= req;
    end else begin
      case (state)
        ST_ASSERT: begin
          bus.rst_o       <= '1;
          bus.done_o      <= 1'b0;
          bus.led_reset_o <= 1'b1;
          state           <= ST_WAIT_RELEASE;
        end
        ST_WAIT_RELEASE: begin
          if (!req_any) begin
            hold_cnt <= HW'(HOLD_CLKS - 1);
            state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == '0) begin
            bus.rst_o[0] <= 1'b0;
            if (NUM_DOMAINS == 1) begin
              bus.done_o      <= 1'b1;
              bus.led_reset_o <= 1'b0;
              state           <= ST_RUNNING;
            end else begin
              dom_idx  <= IW'(1);
              stag_cnt <= SW'(STAGGER_CLKS - 1);
              state    <= ST_RELEASE;
            end
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        ST_RELEASE: begin
          if (stag_cnt == '0) begin
            bus.rst_o <= bus.rst_o & ~(NUM_DOMAINS'(1) << dom_idx);
            if (dom_idx == IW'(NUM_DOMAINS - 1)) begin
              bus.done_o      <= 1'b1;
              bus.led_reset_o <= 1'b0;
              state           <= ST_RUNNING;
            end else begin
              dom_idx  <= dom_idx + IW'(1);
              stag_cnt <= SW'(STAGGER_CLKS - 1);
            end
          end else begin
            stag_cnt <= stag_cnt - SW'(1);
          end
        end
        ST_RUNNING: begin
          bus.done_o      <= 1'b1;
          bus.led_reset_o <= 1'b0;
        end
        default: state <= ST_ASSERT;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with default parameters.
// Edge numbers count rising edges after an input change made between edges.
module tb_reset_sequencer;

  logic clk = 1'b0;
  logic reset_i;
  int   checks   = 0;
  int   failures = 0;

  reset_sequencer_if #(.NUM_SOURCES(2), .NUM_DOMAINS(3)) bus ();

  reset_sequencer dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full release sequence; HOLD is entered on edge n, so rst_o[0] falls on
  // n+7, rst_o[1] on n+11, rst_o[2] and done on n+15.
  task automatic run_seq(input int n, input logic [1:0] exp_cause);
    logic [2:0] exp_rst;
    for (int e = 1; e <= n + 15; e++) begin
      step();
      if (e < n + 7)       exp_rst = 3'b111;
      else if (e < n + 11) exp_rst = 3'b110;
      else if (e < n + 15) exp_rst = 3'b100;
      else                 exp_rst = 3'b000;
      check($sformatf("seq_rst[e%0d]", e), bus.rst_o, exp_rst);
      check($sformatf("seq_done[e%0d]", e), bus.done_o, (e == n + 15));
      check($sformatf("seq_led[e%0d]", e), bus.led_reset_o, (e < n + 15));
      check($sformatf("seq_cause[e%0d]", e), bus.cause_o, exp_cause);
    end
  endtask

  // From RUNNING, drive a request pattern for len edges; entry lands on edge 19.
  task automatic press(input logic [1:0] act, input int len,
                       input logic [1:0] old_cause, input logic [1:0] new_cause);
    bus.src_i = act;
    for (int e = 1; e <= len; e++) begin
      step();
      check($sformatf("press_rst[e%0d]", e), bus.rst_o,
            (e < 19) ? 3'b000 : 3'b111);
      check($sformatf("press_done[e%0d]", e), bus.done_o, (e < 19));
      check($sformatf("press_led[e%0d]", e), bus.led_reset_o, (e >= 19));
      check($sformatf("press_cause[e%0d]", e), bus.cause_o,
            (e < 19) ? old_cause : new_cause);
    end
  endtask

  initial begin
    // Power-on reset with both sources inactive.
    bus.src_i = 2'b10;
    reset_i   = 1'b0;
    #1 reset_i = 1'b1;
    #2;
    check("por_rst", bus.rst_o, 3'b111);
    check("por_led", bus.led_reset_o, 1'b1);
    check("por_done", bus.done_o, 1'b0);
    check("por_cause", bus.cause_o, 2'b00);
    repeat (2) step();
    check("por_held_rst", bus.rst_o, 3'b111);
    #3 reset_i = 1'b0;
    run_seq(2, 2'b00);

    // Long press on source 0.
    press(2'b11, 30, 2'b00, 2'b01);
    bus.src_i = 2'b10;
    run_seq(19, 2'b01);

    // Ten-cycle glitch on active-low source 1 must be filtered.
    bus.src_i = 2'b00;
    for (int e = 1; e <= 40; e++) begin
      step();
      if (e == 10) bus.src_i = 2'b10;
      check($sformatf("glitch_rst[e%0d]", e), bus.rst_o, 3'b000);
      check($sformatf("glitch_done[e%0d]", e), bus.done_o, 1'b1);
      check($sformatf("glitch_cause[e%0d]", e), bus.cause_o, 2'b01);
    end

    // Both sources together; source 1 released first, source 0 ten edges later.
    press(2'b01, 30, 2'b01, 2'b11);
    bus.src_i = 2'b11;
    for (int e = 1; e <= 10; e++) begin
      step();
      check($sformatf("simul_rst[e%0d]", e), bus.rst_o, 3'b111);
      check($sformatf("simul_cause[e%0d]", e), bus.cause_o, 2'b11);
    end
    bus.src_i = 2'b10;
    run_seq(19, 2'b11);

    // Source 1 starts a sequence; a 25-cycle pulse on source 0 lands its
    // debounced rise on edge 31, one after rst_o[1] falls on edge 30.
    press(2'b00, 30, 2'b11, 2'b10);
    bus.src_i = 2'b10;
    for (int e = 1; e <= 38; e++) begin
      logic [2:0] exp_rst;
      step();
      if (e < 26)      exp_rst = 3'b111;
      else if (e < 30) exp_rst = 3'b110;
      else if (e < 32) exp_rst = 3'b100;
      else             exp_rst = 3'b111;
      check($sformatf("mid_rst[e%0d]", e), bus.rst_o, exp_rst);
      check($sformatf("mid_done[e%0d]", e), bus.done_o, 1'b0);
      check($sformatf("mid_cause[e%0d]", e), bus.cause_o,
            (e < 32) ? 2'b10 : 2'b01);
      if (e == 13) bus.src_i = 2'b11;
    end
    bus.src_i = 2'b10;
    run_seq(19, 2'b01);

    // Asynchronous reset between edges while RUNNING.
    #3 reset_i = 1'b1;
    #1;
    check("async_rst", bus.rst_o, 3'b111);
    check("async_led", bus.led_reset_o, 1'b1);
    check("async_done", bus.done_o, 1'b0);
    check("async_cause", bus.cause_o, 2'b00);
    repeat (2) step();
    #3 reset_i = 1'b0;
    run_seq(2, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
